// File: rtl/framer_v2.sv
// framer_v2: wraps a payload byte stream into sync/header/payload/optional CRC-16 frames
module framer_v2 #(
    parameter int          DATA_WIDTH = 8,
    parameter int          MAX_LEN    = 1024,
    parameter logic [15:0] SYNC_WORD  = 16'hEB90,
    parameter bit          CRC_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_frame,
    output logic                  start_ready,
    input  logic [1:0]            frame_type,
    input  logic [15:0]           txfn,
    input  logic [15:0]           payload_len,
    input  logic                  payload_valid,
    input  logic [DATA_WIDTH-1:0] payload_data,
    output logic                  payload_ready,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic [DATA_WIDTH-1:0] frame_data,
    output logic                  frame_sof,
    output logic                  frame_eof,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  len_err
);
    if (DATA_WIDTH != 8) begin : g_bad_width
        $error("framer_v2: DATA_WIDTH must be 8");
    end

    typedef enum logic [2:0] {IDLE, SYNC, HDR, PAYLOAD, CRC} state_t;

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx, crc, txfn_q, len_q, pend_txfn, pend_len;
    logic [1:0]  type_q, pend_type;
    logic        pend_v, xfer, last, accept, len_ok, go, eof_raw;

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        return r;
    endfunction

    assign frame_valid   = (state == PAYLOAD) ? payload_valid : (state != IDLE);
    assign payload_ready = (state == PAYLOAD) && frame_ready;
    assign frame_sof     = (state == SYNC) && (cnt == 16'd0);
    assign eof_raw       = CRC_EN ? (state == CRC) && cnt[0] : (state == PAYLOAD) && (cnt == len_q - 16'd1);
    assign frame_eof     = eof_raw && frame_valid;
    assign start_ready   = (state == IDLE) || frame_eof;
    assign busy          = state != IDLE;
    assign xfer          = frame_valid && frame_ready;
    assign last          = xfer && frame_eof;
    assign accept        = start_frame && start_ready;
    assign len_ok        = (payload_len != 16'd0) && (int'(payload_len) <= MAX_LEN);
    assign go            = accept && len_ok;

    always_comb begin
        frame_data = '0;
        case (state)
            SYNC:    frame_data = cnt[0] ? SYNC_WORD[7:0] : SYNC_WORD[15:8];
            HDR:     frame_data = (cnt[2:0] == 3'd0) ? {6'b0, type_q} :
                                  (cnt[2:0] == 3'd1) ? txfn_q[15:8] :
                                  (cnt[2:0] == 3'd2) ? txfn_q[7:0] :
                                  (cnt[2:0] == 3'd3) ? len_q[15:8] : len_q[7:0];
            PAYLOAD: frame_data = payload_data;
            CRC:     frame_data = cnt[0] ? crc[7:0] : crc[15:8];
            default: frame_data = '0;
        endcase
    end

    // The final byte hands over straight to SYNC when a request is waiting or arrives with it
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == IDLE) begin
            if (go) state_nx = SYNC;
        end else if (last) begin
            state_nx = (go || pend_v) ? SYNC : IDLE;
            cnt_nx   = '0;
        end else if (xfer) begin
            cnt_nx = cnt + 16'd1;
            case (state)
                SYNC:    if (cnt[0]) begin state_nx = HDR; cnt_nx = '0; end
                HDR:     if (cnt[2:0] == 3'd4) begin state_nx = PAYLOAD; cnt_nx = '0; end
                PAYLOAD: if (cnt == len_q - 16'd1) begin state_nx = CRC; cnt_nx = '0; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            crc        <= 16'hFFFF;
            type_q     <= '0;
            txfn_q     <= '0;
            len_q      <= '0;
            pend_v     <= 1'b0;
            pend_type  <= '0;
            pend_txfn  <= '0;
            pend_len   <= '0;
            frame_done <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            frame_done <= last;
            len_err    <= accept && !len_ok;
            if (go && (state == IDLE || last)) begin
                type_q <= frame_type;
                txfn_q <= txfn;
                len_q  <= payload_len;
            end else if (last && pend_v) begin
                type_q <= pend_type;
                txfn_q <= pend_txfn;
                len_q  <= pend_len;
            end
            if (go && state != IDLE && !last) begin
                pend_type <= frame_type;
                pend_txfn <= txfn;
                pend_len  <= payload_len;
            end
            pend_v <= last ? 1'b0 : (go && state != IDLE) ? 1'b1 : pend_v;
            crc    <= (state == IDLE || last) ? 16'hFFFF :
                      (xfer && (state == HDR || state == PAYLOAD)) ? crc_upd(crc, frame_data) : crc;
        end
    end
endmodule

// File: tb/tb_framer_v2.sv
// tb_framer_v2: directed checks of framer_v2 with and without CRC trailer
module tb_framer_v2;
    logic        clk, rst_n, start_frame, start_frame2, payload_valid, frame_ready;
    logic [1:0]  frame_type;
    logic [15:0] txfn, payload_len;
    logic [7:0]  payload_data, frame_data, frame_data2;
    logic start_ready, payload_ready, frame_valid, frame_sof, frame_eof, busy, frame_done, len_err;
    logic start_ready2, payload_ready2, frame_valid2, frame_sof2, frame_eof2, busy2, frame_done2, len_err2;

    int checks = 0, errors = 0;
    logic [7:0] got[$], exp_q[$];
    int sofs[$], eofs[$];
    int dones, unstable, pr_bad, gaps, busy_low;

    framer_v2 dut (
        .clk(clk), .rst_n(rst_n), .start_frame(start_frame), .start_ready(start_ready),
        .frame_type(frame_type), .txfn(txfn), .payload_len(payload_len),
        .payload_valid(payload_valid), .payload_data(payload_data), .payload_ready(payload_ready),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_data(frame_data),
        .frame_sof(frame_sof), .frame_eof(frame_eof), .busy(busy), .frame_done(frame_done),
        .len_err(len_err)
    );

    framer_v2 #(.CRC_EN(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .start_frame(start_frame2), .start_ready(start_ready2),
        .frame_type(frame_type), .txfn(txfn), .payload_len(payload_len),
        .payload_valid(payload_valid), .payload_data(payload_data), .payload_ready(payload_ready2),
        .frame_valid(frame_valid2), .frame_ready(frame_ready), .frame_data(frame_data2),
        .frame_sof(frame_sof2), .frame_eof(frame_eof2), .busy(busy2), .frame_done(frame_done2),
        .len_err(len_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame builder; CRC computed MSB-first by shifting the message into the register
    task automatic add_frame(input logic [1:0] ty, input logic [15:0] fn, input logic [15:0] n,
                             input logic [7:0] pb, input bit ce);
        logic [7:0]  b[$];
        logic [15:0] c;
        c = 16'hFFFF;
        b = '{8'hEB, 8'h90, {6'b0, ty}, fn[15:8], fn[7:0], n[15:8], n[7:0]};
        for (int i = 0; i < int'(n); i++) b.push_back(pb);
        if (ce) begin
            for (int i = 2; i < b.size(); i++) begin
                c = c ^ {b[i], 8'h00};
                for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
            end
            b.push_back(c[15:8]);
            b.push_back(c[7:0]);
        end
        foreach (b[i]) exp_q.push_back(b[i]);
    endtask

    task automatic request(input bit which, input logic [1:0] ty, input logic [15:0] fn, input logic [15:0] n);
        @(negedge clk);
        frame_type  = ty;
        txfn        = fn;
        payload_len = n;
        if (which) start_frame2 = 1'b1;
        else start_frame = 1'b1;
    endtask

    task automatic collect(input bit which, input int nbytes, input bit bp, input int plen,
                           input int flen, input int drop_at, input int budget, input int tail);
        logic [9:0] prev;
        logic [7:0] fd;
        logic fv, fs, fe, pr, bz;
        bit have_prev;
        int pos;
        have_prev = 0;
        prev = '0;
        got.delete(); sofs.delete(); eofs.delete();
        dones = 0; unstable = 0; pr_bad = 0; gaps = 0; busy_low = 0;
        for (int c = 0; c < budget && got.size() < nbytes; c++) begin
            @(negedge clk);
            if (got.size() >= drop_at) begin start_frame = 1'b0; start_frame2 = 1'b0; end
            frame_ready   = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            payload_valid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            fv = which ? frame_valid2 : frame_valid;
            fd = which ? frame_data2 : frame_data;
            fs = which ? frame_sof2 : frame_sof;
            fe = which ? frame_eof2 : frame_eof;
            pr = which ? payload_ready2 : payload_ready;
            bz = which ? busy2 : busy;
            pos = got.size() % flen;
            if (pr !== ((pos >= 7 && pos < 7 + plen) && frame_ready)) pr_bad++;
            if (have_prev && fv && {fd, fs, fe} !== prev) unstable++;
            if (which ? frame_done2 : frame_done) dones++;
            if (!fv) gaps++;
            if (!bz) busy_low++;
            have_prev = fv && !frame_ready;
            prev = {fd, fs, fe};
            if (fv && frame_ready) begin
                if (fs) sofs.push_back(got.size());
                if (fe) eofs.push_back(got.size());
                got.push_back(fd);
            end
        end
        payload_valid = 1'b1;
        frame_ready   = 1'b1;
        repeat (tail) begin
            @(negedge clk);
            #1;
            if (which ? frame_done2 : frame_done) dones++;
        end
    endtask

    task automatic cmp_bytes(input string tag);
        chk({tag, " count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("%s byte %0d", tag, i), got[i], exp_q[i]);
    endtask

    task automatic len_reject(input logic [15:0] n);
        request(0, 2'd0, 16'h0001, n);
        @(negedge clk);
        start_frame = 1'b0;
        #1;
        chk($sformatf("len %0d err pulse", n), {len_err, busy, frame_valid}, 3'b100);
        @(negedge clk);
        #1;
        chk($sformatf("len %0d err clear", n), {len_err, busy, frame_valid}, 3'b000);
    endtask

    initial begin
        rst_n = 1'b0; start_frame = 1'b0; start_frame2 = 1'b0; frame_type = '0; txfn = '0;
        payload_len = '0; payload_valid = 1'b1; payload_data = 8'hAA; frame_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("reset outputs", {frame_valid, payload_ready, frame_sof, frame_eof, busy, frame_done, len_err, start_ready}, 8'b0000_0001);
        chk("reset data", frame_data, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("idle ignores payload", {frame_valid, payload_ready, busy, start_ready}, 4'b0001);

        // single frame, no backpressure
        request(0, 2'd1, 16'h1234, 16'd20);
        collect(0, 29, 0, 20, 29, 0, 200, 3);
        exp_q.delete();
        add_frame(2'd1, 16'h1234, 16'd20, 8'hAA, 1'b1);
        cmp_bytes("single");
        chk("single sof", sofs.size() == 1 ? sofs[0] : -1, 0);
        chk("single eof", eofs.size() == 1 ? eofs[0] : -1, 28);
        chk("single done", dones, 1);
        chk("single gaps", gaps, 0);
        chk("single payload_ready", pr_bad, 0);
        chk("single idle after", {busy, frame_valid}, 2'b00);

        // back-to-back: second request held through frame 1
        request(0, 2'd1, 16'h1234, 16'd20);
        @(posedge clk);
        #1;
        txfn = 16'h1235;
        collect(0, 58, 0, 20, 29, 29, 300, 3);
        exp_q.delete();
        add_frame(2'd1, 16'h1234, 16'd20, 8'hAA, 1'b1);
        add_frame(2'd1, 16'h1235, 16'd20, 8'hAA, 1'b1);
        cmp_bytes("b2b");
        chk("b2b sof2", sofs.size() == 2 ? sofs[1] : -1, 29);
        chk("b2b eof2", eofs.size() == 2 ? eofs[1] : -1, 57);
        chk("b2b done", dones, 2);
        chk("b2b gaps", gaps, 0);
        chk("b2b busy low", busy_low, 0);
        chk("b2b payload_ready", pr_bad, 0);

        // random backpressure and payload underruns
        request(0, 2'd1, 16'h1234, 16'd20);
        collect(0, 29, 1, 20, 29, 0, 2000, 3);
        exp_q.delete();
        add_frame(2'd1, 16'h1234, 16'd20, 8'hAA, 1'b1);
        cmp_bytes("bp");
        chk("bp stable", unstable, 0);
        chk("bp eof", eofs.size() == 1 ? eofs[0] : -1, 28);
        chk("bp done", dones, 1);
        chk("bp payload_ready", pr_bad, 0);

        len_reject(16'd0);
        len_reject(16'd1025);

        // MAX_LEN is accepted; reset lands on payload byte 10
        payload_data = 8'h3C;
        request(0, 2'd2, 16'hBEEF, 16'd1024);
        collect(0, 16, 0, 1024, 1033, 0, 100, 0);
        chk("maxlen bytes", got.size(), 16);
        @(negedge clk);
        #1;
        chk("pre-reset byte", {frame_valid, frame_data}, 9'h13C);
        rst_n = 1'b0;
        #1;
        chk("midreset outputs", {frame_valid, payload_ready, frame_sof, frame_eof, busy, frame_done, len_err, start_ready}, 8'b0000_0001);
        chk("midreset data", frame_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (frame_done || frame_valid || busy) dones++;
        end
        chk("post-reset quiet", dones, 0);
        payload_data = 8'h5C;
        request(0, 2'd2, 16'h0042, 16'd3);
        collect(0, 12, 0, 3, 12, 0, 100, 3);
        exp_q.delete();
        add_frame(2'd2, 16'h0042, 16'd3, 8'h5C, 1'b1);
        cmp_bytes("post-reset");
        chk("post-reset done", dones, 1);

        // CRC-less instance, single payload byte
        payload_data = 8'h7E;
        request(1, 2'd3, 16'h00FF, 16'd1);
        collect(1, 8, 0, 1, 8, 0, 100, 3);
        exp_q.delete();
        exp_q = '{8'hEB, 8'h90, 8'h03, 8'h00, 8'hFF, 8'h00, 8'h01, 8'h7E};
        cmp_bytes("nocrc");
        chk("nocrc sof", sofs.size() == 1 ? sofs[0] : -1, 0);
        chk("nocrc eof", eofs.size() == 1 ? eofs[0] : -1, 7);
        chk("nocrc done", dones, 1);
        chk("nocrc payload_ready", pr_bad, 0);
        chk("nocrc idle after", {busy2, frame_valid2}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/framer_v2.md
FRAMER_V2 -- requirements
Module: framer_v2

Interface
REQ-001 Parameter DATA_WIDTH, default 8; payload and frame byte width; only 8 is legal, and the block SHALL flag other values at elaboration.
REQ-002 Parameter MAX_LEN, default 1024; largest legal payload_len in bytes.
REQ-003 Parameter SYNC_WORD, default 16'hEB90; two-byte frame preamble.
REQ-004 Parameter CRC_EN, default 1; 1 = append CRC-16 trailer, 0 = no trailer.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 start_frame  in  1  frame request, qualified by start_ready.
REQ-008 start_ready  out  1  block can accept a request this cycle.
REQ-009 frame_type  in  2  frame type, latched at accept.
REQ-010 txfn  in  16  transmit frame number, latched at accept.
REQ-011 payload_len  in  16  payload byte count, latched at accept.
REQ-012 payload_valid  in  1  payload byte available.
REQ-013 payload_data  in  DATA_WIDTH  payload byte.
REQ-014 payload_ready  out  1  payload byte consumed this cycle when payload_valid=1.
REQ-015 frame_valid  out  1  frame_data valid.
REQ-016 frame_ready  in  1  downstream accepts frame_data.
REQ-017 frame_data  out  DATA_WIDTH  output byte stream.
REQ-018 frame_sof / frame_eof  out  1 each  first / last byte of frame, qualified by frame_valid.
REQ-019 busy  out  1  frame in progress (state not IDLE).
REQ-020 frame_done  out  1  one-cycle pulse after last byte accepted.
REQ-021 len_err  out  1  one-cycle pulse, request rejected.

Function
REQ-022 Transfer rule: a byte transfers on any cycle with frame_valid=1 and frame_ready=1; while frame_valid=1 and frame_ready=0, frame_data, frame_sof and frame_eof SHALL hold stable.
REQ-023 Frame format, MSB-first: SYNC_WORD[15:8], SYNC_WORD[7:0], {6'b0,frame_type}, txfn[15:8], txfn[7:0], len[15:8], len[7:0], len payload bytes, then CRC[15:8], CRC[7:0] if CRC_EN=1.
REQ-024 Frame length: len+9 bytes with CRC_EN=1; len+7 bytes with CRC_EN=0.
REQ-025 States: IDLE, SYNC, HDR, PAYLOAD, CRC (CRC present only when CRC_EN=1).
REQ-026 State transitions: each state advances only on a transfer; a byte counter selects the byte within SYNC (2), HDR (5), PAYLOAD (len) and CRC (2).
REQ-027 Request accept: when start_frame=1 and start_ready=1, the block SHALL latch frame_type, txfn and payload_len.
REQ-028 Length check: if the latched length is 0 or greater than MAX_LEN, the block SHALL pulse len_err the next cycle, SHALL NOT start a frame, and SHALL leave the state unchanged.
REQ-029 start_ready SHALL be 1 in IDLE and while the final frame byte is presented (frame_eof=1); it SHALL be 0 otherwise.
REQ-030 Back-to-back: a request accepted during the final byte is held in a one-deep pending register; on the final-byte transfer the state SHALL go directly to SYNC of the new frame, with SOF on the next cycle and zero idle cycles.
REQ-031 frame_valid: 1 in SYNC, HDR and CRC; in PAYLOAD it equals payload_valid.
REQ-032 payload_ready SHALL equal frame_ready in PAYLOAD and SHALL be 0 in all other states; frame_data SHALL equal payload_data in PAYLOAD.
REQ-033 CRC: CRC-16-CCITT, polynomial 0x1021, init 0xFFFF, no reflection, no final XOR; computed over all header bytes (sync excluded) and all payload bytes; updated only on transfer.
REQ-034 CRC reset: the CRC register SHALL reinitialise to 0xFFFF at each SOF.
REQ-035 frame_done SHALL pulse one cycle after the frame_eof transfer, including when a back-to-back frame follows.
REQ-036 Extra payload bytes: payload_valid outside PAYLOAD SHALL be ignored and no byte consumed.
REQ-037 No timeout: a payload underrun (payload_valid=0) SHALL stall the frame indefinitely.

Reset
REQ-038 When rst_n=0, the block SHALL asynchronously force IDLE and clear counters, the pending register and CRC.
REQ-039 Output values under reset: frame_valid, payload_ready, frame_sof, frame_eof, busy, frame_done and len_err SHALL be 0; frame_data SHALL be 8'h00; start_ready SHALL be 1.
REQ-040 Reset mid-frame SHALL abort the frame with no frame_done and no further bytes; the first request after rst_n rises SHALL be accepted in IDLE.

Verification
REQ-041 Single frame: type=1, txfn=16'h1234, len=20, payload 8'hAA, frame_ready=1 -> 29 bytes EB 90 01 12 34 00 14, then 20x AA, then CRC matching the bench model; frame_done pulses once.
REQ-042 Back-to-back: second request (txfn=16'h1235) held asserted during frame 1 -> SYNC byte EB of frame 2 appears the cycle after frame 1's final byte; busy stays 1 throughout; 58 bytes total.
REQ-043 Backpressure: frame_ready randomly toggled ~50% -> byte sequence identical to REQ-041 and frame_data stable during stalls.
REQ-044 Length errors: len=0, and len=MAX_LEN+1 -> len_err pulse, no frame_valid, busy=0.
REQ-045 CRC_EN=0 variant with len=1 -> 8 bytes and frame_eof on the payload byte.
REQ-046 Reset mid-frame: rst_n low during payload byte 10 -> outputs immediately at their reset values, no frame_done; a new frame after release is correct.
